// File: rtl/fft_input_collect_if.sv
// -----------------------------------------------------------------------------
// fft_input_collect_if
// Bundles the sample stream input and the parallel frame output of the FFT
// input collector.
//   slave  modport : the collector itself
//   master modport : the environment (sample source + FFT core)
// Signals:
//   sample_in     incoming sample, two's complement
//   sample_valid  sample_in is meaningful (qualified by the internal strobe)
//   sample_sync   frame realign: next accepted sample becomes x0
//   x0..x7        frame outputs, x0 = oldest sample of the frame
//   frame_valid   x0..x7 hold an unacknowledged complete frame
//   frame_ack     FFT core has consumed x0..x7
//   wr_index      slot the next accepted sample will fill
//   overrun       sticky flag: a completed frame was dropped
// -----------------------------------------------------------------------------
interface fft_input_collect_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_sync;
  logic [WIDTH-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic             frame_valid;
  logic             frame_ack;
  logic [2:0]       wr_index;
  logic             overrun;

  modport master (
    output sample_in, sample_valid, sample_sync, frame_ack,
    input  x0, x1, x2, x3, x4, x5, x6, x7, frame_valid, wr_index, overrun
  );

  modport slave (
    input  sample_in, sample_valid, sample_sync, frame_ack,
    output x0, x1, x2, x3, x4, x5, x6, x7, frame_valid, wr_index, overrun
  );
endinterface

// File: rtl/fft_input_collect.sv
// -----------------------------------------------------------------------------
// fft_input_collect
// Serial-to-parallel sample collector in front of the 8-point FFT. One sample
// is taken per sample strobe (a clock enable every DIV+1 fastclk cycles) when
// sample_valid is high. Eight samples form a frame, which is handed to the FFT
// core on x0..x7 with a frame_valid / frame_ack handshake. A shadow buffer
// collects the next frame while the current one is still being presented.
// Ports:
//   fastclk  system clock, all logic on its rising edge
//   rst      synchronous, active-high reset
//   bus      fft_input_collect_if.slave (sample stream in, frame out)
// -----------------------------------------------------------------------------
module fft_input_collect #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25
) (
  input  logic                 fastclk,
  input  logic                 rst,
  fft_input_collect_if.slave   bus
);

  localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);

  logic [CW-1:0]    r_div_cnt;
  logic [WIDTH-1:0] r_shadow [0:6];   // slot 7 goes straight to the output
  logic [WIDTH-1:0] r_x      [0:7];
  logic [2:0]       r_wr_index;
  logic             r_frame_valid;
  logic             r_overrun;

  logic w_strobe;
  logic w_accept;
  logic w_complete;
  logic w_load;

  assign w_strobe   = (r_div_cnt == CW'(DIV));
  assign w_accept   = w_strobe & bus.sample_valid;
  // A sync on the eighth sample restarts the frame rather than completing it.
  assign w_complete = w_accept & ~bus.sample_sync & (r_wr_index == 3'd7);
  // An ack in the completion cycle frees the output registers for the new frame.
  assign w_load     = w_complete & (~r_frame_valid | bus.frame_ack);

  // Sample strobe divider: a clock enable, not a derived clock.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_strobe) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  // Shadow collection buffer and write pointer.
  // NOTE: the shadow buffer is reset explicitly because its contents are
  // defined to read as zero after reset; this keeps it in flops, not RAM.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      r_wr_index <= 3'd0;
      for (int i = 0; i < 7; i++) r_shadow[i] <= '0;
    end else if (bus.sample_sync) begin
      // Realign: a partial frame is abandoned by rewinding the pointer.
      if (w_accept) begin
        r_shadow[0] <= bus.sample_in;
        r_wr_index  <= 3'd1;
      end else begin
        r_wr_index  <= 3'd0;
      end
    end else if (w_accept) begin
      if (r_wr_index != 3'd7) r_shadow[r_wr_index] <= bus.sample_in;
      r_wr_index <= r_wr_index + 3'd1;
    end
  end

  // Output frame registers and handshake.
  always_ff @(posedge fastclk) begin
    if (rst) begin
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < 8; i++) r_x[i] <= '0;
    end else if (w_complete) begin
      if (w_load) begin
        for (int i = 0; i < 7; i++) r_x[i] <= r_shadow[i];
        r_x[7]        <= bus.sample_in;
        r_frame_valid <= 1'b1;
      end else begin
        // Previous frame still unconsumed: keep it and drop the new one.
        r_overrun <= 1'b1;
      end
    end else if (bus.frame_ack && r_frame_valid) begin
      r_frame_valid <= 1'b0;
    end
  end

  assign bus.x0          = r_x[0];
  assign bus.x1          = r_x[1];
  assign bus.x2          = r_x[2];
  assign bus.x3          = r_x[3];
  assign bus.x4          = r_x[4];
  assign bus.x5          = r_x[5];
  assign bus.x6          = r_x[6];
  assign bus.x7          = r_x[7];
  assign bus.frame_valid = r_frame_valid;
  assign bus.wr_index    = r_wr_index;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_fft_input_collect.sv
// -----------------------------------------------------------------------------
// tb_fft_input_collect
// Two collectors (DIV=2 and DIV=0) driven by the same stimulus. A frame-level
// reference model (cycle count since reset, list of accepted samples, output
// frame and flags) predicts every output.
// -----------------------------------------------------------------------------
module tb_fft_input_collect;

  localparam int W = 8;

  logic fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  logic         rst      = 1'b1;
  logic [W-1:0] in_sample = '0;
  logic         in_valid = 1'b0;
  logic         in_sync  = 1'b0;
  logic         in_ack   = 1'b0;

  fft_input_collect_if #(.WIDTH(W)) bus2 ();
  fft_input_collect_if #(.WIDTH(W)) bus0 ();

  assign bus2.sample_in    = in_sample;
  assign bus2.sample_valid = in_valid;
  assign bus2.sample_sync  = in_sync;
  assign bus2.frame_ack    = in_ack;
  assign bus0.sample_in    = in_sample;
  assign bus0.sample_valid = in_valid;
  assign bus0.sample_sync  = in_sync;
  assign bus0.frame_ack    = in_ack;

  fft_input_collect #(.WIDTH(W), .DIV(2)) u_dut2 (
    .fastclk (fastclk),
    .rst     (rst),
    .bus     (bus2.slave)
  );

  fft_input_collect #(.WIDTH(W), .DIV(0)) u_dut0 (
    .fastclk (fastclk),
    .rst     (rst),
    .bus     (bus0.slave)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (index 0: DIV=2, index 1: DIV=0) --------
  int           m_cyc   [2];
  logic [W-1:0] m_buf   [2][8];
  int           m_cnt   [2];
  logic [8*W-1:0] m_frame [2];
  bit           m_fv    [2];
  bit           m_ovr   [2];

  function automatic int div_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // Strobe in the coming cycle: every DIV+1 cycles, first one DIV cycles in.
  function automatic bit strobe_next(int k);
    return (m_cyc[k] % (div_of(k) + 1)) == div_of(k);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cyc[k] = 0; m_cnt[k] = 0; m_frame[k] = '0; m_fv[k] = 0; m_ovr[k] = 0;
      end else begin
        bit acc;
        bit done;
        acc  = strobe_next(k) && in_valid;
        done = 0;
        if (in_sync) begin
          m_cnt[k] = 0;
          if (acc) begin m_buf[k][0] = in_sample; m_cnt[k] = 1; end
        end else if (acc) begin
          m_buf[k][m_cnt[k]] = in_sample;
          m_cnt[k]++;
          if (m_cnt[k] == 8) begin done = 1; m_cnt[k] = 0; end
        end
        if (done) begin
          if (!m_fv[k] || in_ack) begin
            for (int i = 0; i < 8; i++) m_frame[k][(7-i)*W +: W] = m_buf[k][i];
            m_fv[k] = 1;
          end else begin
            m_ovr[k] = 1;
          end
        end else if (in_ack && m_fv[k]) begin
          m_fv[k] = 0;
        end
        m_cyc[k]++;
      end
    end
  endtask

  // ---------------- DUT observation helpers ---------------------------------
  function automatic logic [8*W-1:0] dut_frame(int k);
    if (k == 0) return {bus2.x0, bus2.x1, bus2.x2, bus2.x3, bus2.x4, bus2.x5, bus2.x6, bus2.x7};
    return {bus0.x0, bus0.x1, bus0.x2, bus0.x3, bus0.x4, bus0.x5, bus0.x6, bus0.x7};
  endfunction
  function automatic logic dut_fv(int k);
    return (k == 0) ? bus2.frame_valid : bus0.frame_valid;
  endfunction
  function automatic logic dut_ovr(int k);
    return (k == 0) ? bus2.overrun : bus0.overrun;
  endfunction
  function automatic logic [2:0] dut_wr(int k);
    return (k == 0) ? bus2.wr_index : bus0.wr_index;
  endfunction

  // ---------------- stimulus primitives --------------------------------------
  // Advance one clock; inputs change and outputs are sampled 1 time unit after.
  task automatic tick();
    @(posedge fastclk);
    model_step();
    #1;
  endtask

  // Offer v to the DIV=2 collector until its strobe takes it; optionally
  // raise frame_ack only in the accepting cycle.
  task automatic send(input logic [W-1:0] v, input bit ack_at_accept);
    bit s;
    in_sample = v;
    in_valid  = 1'b1;
    for (int n = 0; n < 8; n++) begin
      s = strobe_next(0);
      in_ack = ack_at_accept && s;
      tick();
      if (s) break;
    end
    in_valid = 1'b0;
    in_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic ack_frame();
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    do_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_fv(k) !== 1'b0) begin errors++; $display("FAIL reset_fv[%0d]: got %b want 0", k, dut_fv(k)); end
      checks++;
      if (dut_ovr(k) !== 1'b0) begin errors++; $display("FAIL reset_ovr[%0d]: got %b want 0", k, dut_ovr(k)); end
      checks++;
      if (dut_wr(k) !== 3'd0) begin errors++; $display("FAIL reset_wr[%0d]: got %0d want 0", k, dut_wr(k)); end
      checks++;
      if (dut_frame(k) !== 64'h0) begin errors++; $display("FAIL reset_x[%0d]: got %h want 0", k, dut_frame(k)); end
    end
    // Ack with no frame pending has no effect.
    ack_frame();
    checks++;
    if (dut_fv(0) !== 1'b0) begin errors++; $display("FAIL idle_ack_fv: got %b want 0", dut_fv(0)); end
    checks++;
    if (dut_wr(0) !== 3'd0) begin errors++; $display("FAIL idle_ack_wr: got %0d want 0", dut_wr(0)); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    for (int v = 1; v <= 8; v++) begin
      if (v == 8) begin
        checks++;
        if (dut_fv(0) !== 1'b0) begin errors++; $display("FAIL basic_early_fv: got %b want 0", dut_fv(0)); end
        checks++;
        if (dut_wr(0) !== 3'd7) begin errors++; $display("FAIL basic_wr7: got %0d want 7", dut_wr(0)); end
      end
      send(W'(v), 1'b0);
    end
    checks++;
    if (dut_fv(0) !== 1'b1) begin errors++; $display("FAIL basic_fv_latency: got %b want 1", dut_fv(0)); end
    checks++;
    if (dut_frame(0) !== 64'h0102030405060708) begin
      errors++; $display("FAIL basic_frame: got %h want 0102030405060708", dut_frame(0));
    end
    checks++;
    if (dut_wr(0) !== 3'd0) begin errors++; $display("FAIL basic_wr_wrap: got %0d want 0", dut_wr(0)); end
    ack_frame();
    checks++;
    if (dut_fv(0) !== 1'b0) begin errors++; $display("FAIL basic_ack_fv: got %b want 0", dut_fv(0)); end
  endtask

  task automatic test_valid_toggle();
    logic [W-1:0] q[$];
    logic [8*W-1:0] exp_frame;
    bit tog;
    bit s;
    tog = 1'b1;
    for (int n = 0; n < 200 && q.size() < 8; n++) begin
      in_sample = W'($urandom);
      s = strobe_next(0);
      if (s) begin
        in_valid = tog;
        if (tog) q.push_back(in_sample);
        tog = !tog;
      end else begin
        in_valid = 1'($urandom);   // off-strobe offers must be ignored
      end
      tick();
      checks++;
      if (dut_wr(0) !== 3'(q.size() % 8)) begin
        errors++; $display("FAIL toggle_wr: got %0d want %0d", dut_wr(0), q.size() % 8);
      end
    end
    in_valid = 1'b0;
    exp_frame = '0;
    for (int i = 0; i < q.size(); i++) exp_frame[(7-i)*W +: W] = q[i];
    checks++;
    if (dut_fv(0) !== 1'b1) begin errors++; $display("FAIL toggle_fv: got %b want 1", dut_fv(0)); end
    checks++;
    if (dut_frame(0) !== exp_frame) begin errors++; $display("FAIL toggle_frame: got %h want %h", dut_frame(0), exp_frame); end
    checks++;
    if (dut_frame(0) !== m_frame[0]) begin errors++; $display("FAIL toggle_model: got %h want %h", dut_frame(0), m_frame[0]); end
    ack_frame();
  endtask

  task automatic test_sync();
    for (int i = 0; i < 3; i++) send(W'($urandom), 1'b0);
    in_sync = 1'b1;
    tick();
    in_sync = 1'b0;
    checks++;
    if (dut_wr(0) !== 3'd0) begin errors++; $display("FAIL sync_wr: got %0d want 0", dut_wr(0)); end
    for (int v = 10; v <= 17; v++) send(W'(v), 1'b0);
    checks++;
    if (dut_frame(0) !== 64'h0A0B0C0D0E0F1011) begin
      errors++; $display("FAIL sync_frame: got %h want 0a0b0c0d0e0f1011", dut_frame(0));
    end
    checks++;
    if (dut_fv(0) !== 1'b1) begin errors++; $display("FAIL sync_fv: got %b want 1", dut_fv(0)); end
    ack_frame();
  endtask

  task automatic test_overrun();
    logic [8*W-1:0] a;
    a = '0;
    for (int i = 0; i < 8; i++) begin
      a[(7-i)*W +: W] = W'($urandom);
      send(a[(7-i)*W +: W], 1'b0);
    end
    checks++;
    if (dut_frame(0) !== a) begin errors++; $display("FAIL ovr_frame_a: got %h want %h", dut_frame(0), a); end
    for (int i = 0; i < 8; i++) send(W'($urandom), 1'b0);
    checks++;
    if (dut_frame(0) !== a) begin errors++; $display("FAIL ovr_kept_a: got %h want %h", dut_frame(0), a); end
    checks++;
    if (dut_ovr(0) !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", dut_ovr(0)); end
    checks++;
    if (dut_fv(0) !== 1'b1) begin errors++; $display("FAIL ovr_fv: got %b want 1", dut_fv(0)); end
    ack_frame();
    checks++;
    if (dut_fv(0) !== 1'b0) begin errors++; $display("FAIL ovr_ack_fv: got %b want 0", dut_fv(0)); end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (dut_ovr(0) !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", dut_ovr(0)); end
  endtask

  task automatic test_ack_on_completion();
    logic [8*W-1:0] b;
    do_reset();
    for (int i = 0; i < 8; i++) send(W'($urandom), 1'b0);
    checks++;
    if (dut_fv(0) !== 1'b1) begin errors++; $display("FAIL ackc_fv_a: got %b want 1", dut_fv(0)); end
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[(7-i)*W +: W] = W'($urandom);
      send(b[(7-i)*W +: W], i == 7);
    end
    checks++;
    if (dut_frame(0) !== b) begin errors++; $display("FAIL ackc_frame_b: got %h want %h", dut_frame(0), b); end
    checks++;
    if (dut_fv(0) !== 1'b1) begin errors++; $display("FAIL ackc_fv_b: got %b want 1", dut_fv(0)); end
    checks++;
    if (dut_ovr(0) !== 1'b0) begin errors++; $display("FAIL ackc_ovr: got %b want 0", dut_ovr(0)); end
    ack_frame();
  endtask

  task automatic test_mid_reset();
    logic [8*W-1:0] c;
    for (int i = 0; i < 5; i++) send(W'($urandom), 1'b0);
    do_reset();
    checks++;
    if (dut_wr(0) !== 3'd0) begin errors++; $display("FAIL mrst_wr: got %0d want 0", dut_wr(0)); end
    checks++;
    if (dut_frame(0) !== 64'h0) begin errors++; $display("FAIL mrst_x: got %h want 0", dut_frame(0)); end
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c[(7-i)*W +: W] = W'($urandom);
      send(c[(7-i)*W +: W], 1'b0);
    end
    checks++;
    if (dut_frame(0) !== c) begin errors++; $display("FAIL mrst_frame: got %h want %h", dut_frame(0), c); end
    checks++;
    if (dut_fv(0) !== 1'b1) begin errors++; $display("FAIL mrst_fv: got %b want 1", dut_fv(0)); end

    // Same scenario on the DIV=0 collector: a sample is taken every cycle.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_sample = W'($urandom); tick(); end
    checks++;
    if (dut_wr(1) !== 3'd5) begin errors++; $display("FAIL div0_wr5: got %0d want 5", dut_wr(1)); end
    do_reset();
    checks++;
    if (dut_wr(1) !== 3'd0) begin errors++; $display("FAIL div0_rst_wr: got %0d want 0", dut_wr(1)); end
    checks++;
    if (dut_fv(1) !== 1'b0 || dut_frame(1) !== 64'h0) begin
      errors++; $display("FAIL div0_rst_out: got fv=%b x=%h want 0", dut_fv(1), dut_frame(1));
    end
    in_valid = 1'b1;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      in_sample = W'($urandom);
      c[(7-i)*W +: W] = in_sample;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (dut_frame(1) !== c) begin errors++; $display("FAIL div0_frame: got %h want %h", dut_frame(1), c); end
    checks++;
    if (dut_fv(1) !== 1'b1) begin errors++; $display("FAIL div0_fv: got %b want 1", dut_fv(1)); end
    checks++;
    if (dut_wr(1) !== 3'd0 || dut_ovr(1) !== 1'b0) begin
      errors++; $display("FAIL div0_wr_ovr: got wr=%0d ovr=%b want 0/0", dut_wr(1), dut_ovr(1));
    end
    // Both collectors against the reference model at the end of the run.
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_frame(k) !== m_frame[k] || dut_fv(k) !== m_fv[k] || dut_ovr(k) !== m_ovr[k]
          || dut_wr(k) !== 3'(m_cnt[k])) begin
        errors++;
        $display("FAIL model_final[%0d]: got x=%h fv=%b ovr=%b wr=%0d want x=%h fv=%b ovr=%b wr=%0d",
                 k, dut_frame(k), dut_fv(k), dut_ovr(k), dut_wr(k),
                 m_frame[k], m_fv[k], m_ovr[k], m_cnt[k]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_frame();
    test_valid_toggle();
    test_sync();
    test_overrun();
    test_ack_on_completion();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
